// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: default widths, register-address type,
// data-word type and the hardwired-zero register index.
package rv_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int REG_ADDR_W    = $clog2(NREGS_DEFAULT);

   typedef logic [REG_ADDR_W-1:0]   reg_addr_t;
   typedef logic [XLEN_DEFAULT-1:0] xword_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv_reg_entry.sv
// One architectural register: W-bit storage with load enable and an
// asynchronous active-low clear.
module rv_reg_entry #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Storage: cleared immediately by reset, loaded on enabled rising edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/rv_reg_file.sv
// Integer register file: NREGS x XLEN, two combinational read ports, one
// synchronous write port, x0 hardwired to zero, plus a per-register busy
// scoreboard (set by decode allocation, cleared by writeback).
// Optional macro REGFILE_BYPASS_EN: forward the writeback data (and a clear
// busy flag) to a read port addressing the register being written.
module rv_reg_file
   import rv_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int NREGS = NREGS_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(NREGS)-1:0] rs1_addr,
   output logic [XLEN-1:0]          rs1_data,
   output logic                     rs1_busy,
   input  logic [$clog2(NREGS)-1:0] rs2_addr,
   output logic [XLEN-1:0]          rs2_data,
   output logic                     rs2_busy,
   input  logic                     wr_en,
   input  logic [$clog2(NREGS)-1:0] wr_addr,
   input  logic [XLEN-1:0]          wr_data,
   input  logic                     alloc_en,
   input  logic [$clog2(NREGS)-1:0] alloc_addr
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             wr_live;
   logic             alloc_live;

   // Requests that target x0 are dropped here so nothing below sees them.
   assign wr_live    = wr_en    && (wr_addr    != AW'(REG_ZERO));
   assign alloc_live = alloc_en && (alloc_addr != AW'(REG_ZERO));

   assign regs[0] = '0;

   for (genvar g = 1; g < NREGS; g++) begin : g_entry
      rv_reg_entry #(.W(XLEN)) u_entry (
         .clk (clk),
         .rst (rst),
         .en  (wr_live && (wr_addr == AW'(g))),
         .d   (wr_data),
         .q   (regs[g])
      );
   end

   // Scoreboard next state: writeback releases, allocation claims; when both
   // hit the same register the claim wins because a newer producer is pending.
   always_comb begin
      busy_nxt = busy;
      if (wr_live) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (alloc_live) begin
         busy_nxt[alloc_addr] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard register, cleared asynchronously with the data storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Read muxes: x0 reads zero/not-busy through regs[0] and busy[0].
   always_comb begin
      rs1_data = regs[rs1_addr];
      rs1_busy = busy[rs1_addr];
      rs2_data = regs[rs2_addr];
      rs2_busy = busy[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (rs1_addr == wr_addr)) begin
         rs1_data = wr_data;
         rs1_busy = 1'b0;
      end
      if (wr_live && (rs2_addr == wr_addr)) begin
         rs2_data = wr_data;
         rs2_busy = 1'b0;
      end
`endif
   end

endmodule

// File: doc/rv_reg_file.md
Name: rv_reg_file

Overview:
Parametrised integer register file for the RISC-V core. It holds NREGS words of XLEN bits, with two asynchronous read ports and one synchronous write port, and register 0 is hardwired to zero. It also carries a per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight writebacks. It sits between decode (reads, allocation) and writeback (writes, release).

Parameters:
XLEN, 32, data width of each register in bits.
NREGS, 32, number of architectural registers (power of two, >= 2).
AW, $clog2(NREGS), register address width (derived localparam, not overridable).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-low reset.
rs1_addr  input  AW  read port 1 address.
rs1_data  output  XLEN  read port 1 data.
rs1_busy  output  1  register rs1_addr has a pending write.
rs2_addr  input  AW  read port 2 address.
rs2_data  output  XLEN  read port 2 data.
rs2_busy  output  1  register rs2_addr has a pending write.
wr_en  input  1  writeback strobe.
wr_addr  input  AW  writeback destination.
wr_data  input  XLEN  writeback data.
alloc_en  input  1  decode issues an instruction that will write alloc_addr.
alloc_addr  input  AW  destination being allocated.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-low.
- Reset (rst=0, asynchronous): all registers clear to 0 and all busy bits clear to 0 immediately, even mid-operation. Read outputs then reflect zeros combinationally.
- Read ports:
  - Purely combinational, zero latency.
  - Address 0 always returns 0 with busy=0.
  - Both ports may address the same register.
- Write:
  - On a rising clk edge with wr_en=1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - Writes to address 0 are discarded.
  - Storage updates are visible on the read ports from the cycle after the edge.
- Read-during-write to the same address (without feature): the read returns the OLD value for the whole cycle.
- Scoreboard:
  - alloc_en=1, alloc_addr != 0: busy[alloc_addr] <= 1 at the edge.
  - wr_en=1, wr_addr != 0: busy[wr_addr] <= 0 at the edge.
  - Same edge, same address, both alloc and write: set wins, so busy stays 1 (a new producer is in flight). Data is still written.
  - Same edge, different addresses: both take effect independently.
  - Alloc of an already-busy register: stays 1, no error.
  - Write to a non-busy register: the data write proceeds and busy stays 0.
  - Busy bit 0 is never set.
- Width rules:
  - Addresses are exactly AW bits, so out-of-range addresses are impossible when NREGS = 2^AW.
  - No sign or zero extension; data passes through unmodified.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. When wr_en=1, wr_addr != 0 and rsN_addr == wr_addr, then rsN_data = wr_data and rsN_busy = 0 combinationally in the same cycle. A simultaneous alloc to that address does not re-assert busy until the next cycle.
- Not defined: no forwarding; behaviour is exactly as above (old data, busy still 1 during the writeback cycle).

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and NREGS default constants.
  - REG_ADDR_W.
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
  - typedef xword_t (logic [XLEN-1:0]).
  - constant REG_ZERO = 0.
- One natural sub-module, rv_reg_entry: a single XLEN-bit register with load enable and asynchronous active-low clear. It is instantiated NREGS-1 times via generate (entry 0 is a constant).
- Scoreboard and read muxes stay in the top module.

Test Plan:
- Reset, then read all addresses on both ports -> every rs1_data/rs2_data = 0, every busy = 0.
- Write 0xDEADBEEF to x5, then read x5 on both ports next cycle -> both return 0xDEADBEEF. Write 0x1234 to x0 -> x0 still reads 0.
- Read x7 while writing 0xA5A5A5A5 to x7 in the same cycle -> old value 0 without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it. Next cycle both configurations return 0xA5A5A5A5.
- Scoreboard on x3:
  - alloc x3 -> rs1_busy=1 next cycle.
  - writeback x3 -> busy=0 next cycle.
  - alloc x3 and writeback x3 on the same edge -> busy remains 1 and data is updated.
  - alloc x0 -> busy stays 0.
- Populate x1..x31 with value i, assert rst low asynchronously between edges -> all data and busy read 0 before the next clk edge. Deassert -> writes resume normally.
- Parameter sweep NREGS=16, XLEN=64: write 0xFFFF_FFFF_0000_0001 to x15 -> readback exact. x0 stays 0.
